// File: rtl/popcnt_share_sched_pkg.sv
// -----------------------------------------------------------------------------
// popcnt_share_sched_pkg
// Shared constants and types for the shared weight (ones-count) scheduler.
//   CHUNK_W  : width of one slice fed to the weight core per cycle
//   WEIGHT_W : width of the core's count output (0..7 fits in 3 bits)
//   state_t  : scheduler FSM states
//   req_id_t : requester identifier (two requesters)
// -----------------------------------------------------------------------------
package popcnt_share_sched_pkg;

  localparam int CHUNK_W  = 7;
  localparam int WEIGHT_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef logic req_id_t;

endpackage

// File: rtl/popcnt_share_sched_popcnt7_core.sv
// -----------------------------------------------------------------------------
// popcnt7_core
// Purely combinational ones-count of a 7-bit slice. Kept as its own module so
// the gate-level weight netlist can be dropped in without touching the
// scheduler.
// Ports:
//   v : input  [6:0] slice to weigh
//   w : output [2:0] binary count of ones in v
// -----------------------------------------------------------------------------
module popcnt7_core
  import popcnt_share_sched_pkg::*;
(
  input  logic [CHUNK_W-1:0]  v,
  output logic [WEIGHT_W-1:0] w
);

  always_comb begin
    w = '0;
    for (int i = 0; i < CHUNK_W; i++) begin
      w = w + WEIGHT_W'(v[i]);
    end
  end

endmodule

// File: rtl/popcnt_share_sched.sv
// -----------------------------------------------------------------------------
// popcnt_share_sched
// Shares one 7-input weight core between two requesters. A granted word is
// captured into a shift register and weighed one 7-bit chunk per cycle, lowest
// chunk first; the total is returned with the winner's id.
//
// Handshake semantics (all channels): a transfer happens on a rising edge
// where valid and ready are both high. Requesters may drop valid at any time
// before a transfer; the result channel holds res_count/res_id stable while
// res_valid is high and res_ready is low.
//
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   req0_valid/ready/data: requester 0 word channel
//   req1_valid/ready/data: requester 1 word channel
//   res_valid/ready      : result channel handshake
//   res_count            : ones count of the accepted word
//   res_id               : requester that supplied the word
//   busy                 : high while in RUN or DONE
//   dbg_state            : current FSM state for observation
// -----------------------------------------------------------------------------
module popcnt_share_sched
  import popcnt_share_sched_pkg::*;
#(
  parameter int CHUNKS = 4,
  parameter int CNT_W  = 5,
  localparam int WORD_W = CHUNK_W * CHUNKS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [WORD_W-1:0] req0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [WORD_W-1:0] req1_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [CNT_W-1:0]  res_count,
  output req_id_t           res_id,
  output logic              busy,
  output state_t            dbg_state
);

  localparam int IDX_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHUNKS - 1);

  // The accumulator must be able to hold WORD_W itself.
  if ((2 ** CNT_W) <= WORD_W) begin : g_cnt_w_check
    $error("popcnt_share_sched: CNT_W too small for WORD_W");
  end

  state_t              state;
  logic [CNT_W-1:0]    acc;
  logic [IDX_W-1:0]    idx;
  logic [WORD_W-1:0]   shreg;
  req_id_t             rr;          // id of the requester preferred on a tie
  logic                grant_valid;
  req_id_t             grant_id;
  logic [WEIGHT_W-1:0] chunk_weight;
  logic [CNT_W-1:0]    acc_sum;

  popcnt7_core u_core (
    .v (shreg[CHUNK_W-1:0]),
    .w (chunk_weight)
  );

  assign acc_sum = acc + CNT_W'(chunk_weight);

  // Grant is only offered in IDLE; a lone valid requester always wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = 1'b0;
    if (state == IDLE) begin
      if (req0_valid && req1_valid) begin
        grant_valid = 1'b1;
        grant_id    = rr;
      end else if (req0_valid) begin
        grant_valid = 1'b1;
        grant_id    = 1'b0;
      end else if (req1_valid) begin
        grant_valid = 1'b1;
        grant_id    = 1'b1;
      end
    end
  end

  assign req0_ready = grant_valid && (grant_id == 1'b0);
  assign req1_ready = grant_valid && (grant_id == 1'b1);
  assign dbg_state  = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      idx       <= '0;
      shreg     <= '0;
      res_valid <= 1'b0;
      res_count <= '0;
      res_id    <= 1'b0;
      busy      <= 1'b0;
      rr        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            shreg  <= grant_id ? req1_data : req0_data;
            res_id <= grant_id;
            acc    <= '0;
            idx    <= '0;
            rr     <= ~grant_id;   // the requester just served loses the next tie
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          acc   <= acc_sum;
          shreg <= shreg >> CHUNK_W;
          idx   <= idx + IDX_W'(1);
          if (idx == LAST_IDX) begin
            res_count <= acc_sum;
            res_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          res_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_popcnt_share_sched.sv
// -----------------------------------------------------------------------------
// tb_popcnt_share_sched
// Directed bench for popcnt_share_sched at default parameters (CHUNKS=4,
// CNT_W=5). Inputs are driven 1 time unit after the rising edge and outputs
// are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_popcnt_share_sched;
  import popcnt_share_sched_pkg::*;

  localparam int CHUNKS = 4;
  localparam int CNT_W  = 5;
  localparam int WORD_W = 28;

  logic              clk = 1'b0;
  logic              rst;
  logic              req0_valid;
  logic              req0_ready;
  logic [WORD_W-1:0] req0_data;
  logic              req1_valid;
  logic              req1_ready;
  logic [WORD_W-1:0] req1_data;
  logic              res_valid;
  logic              res_ready;
  logic [CNT_W-1:0]  res_count;
  req_id_t           res_id;
  logic              busy;
  state_t            dbg_state;

  int n_pass  = 0;
  int n_total = 0;

  // Scoreboard entries are {id, count}.
  logic [CNT_W:0] exp_q[$];

  popcnt_share_sched #(.CHUNKS(CHUNKS), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_data  (req0_data),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_data  (req1_data),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_count  (res_count),
    .res_id     (res_id),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // ---------------- driver tasks / scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_data = '0; req1_data = '0;
    res_ready = 1'b0;
    tick();
    tick();
    @(negedge clk);
    n_total++;
    if ({dbg_state, res_valid, res_count, res_id, busy} !== {IDLE, 1'b0, 5'd0, 1'b0, 1'b0})
      $display("FAIL reset_state: got st=%0d rv=%b cnt=%0d id=%b busy=%b want st=0 rv=0 cnt=0 id=0 busy=0",
               dbg_state, res_valid, res_count, res_id, busy);
    else n_pass++;
    tick();
    rst = 1'b0;
    @(negedge clk);
    n_total++;
    if ({req1_ready, req0_ready} !== 2'b00)
      $display("FAIL reset_ready_idle: got %b%b want 00", req1_ready, req0_ready);
    else n_pass++;
    tick();
  endtask

  // Sends one word from a single requester with res_ready high and checks
  // grant, latency (result in cycle CHUNKS+1), count and id.
  task automatic run_word(input logic id, input logic [WORD_W-1:0] data,
                          input logic [CNT_W-1:0] exp_cnt, input string name);
    int lat;
    res_ready = 1'b1;
    if (id) begin req1_valid = 1'b1; req1_data = data; end
    else    begin req0_valid = 1'b1; req0_data = data; end
    @(negedge clk);
    n_total++;
    if ({req1_ready, req0_ready} !== (id ? 2'b10 : 2'b01))
      $display("FAIL %s_grant: got %b%b want %b", name, req1_ready, req0_ready, (id ? 2'b10 : 2'b01));
    else n_pass++;
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_data = ~data; req1_data = ~data;   // must be ignored after capture
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (res_valid === 1'b1) begin
        lat = k;
        break;
      end
      tick();
    end
    n_total++;
    if (lat !== CHUNKS + 1)
      $display("FAIL %s_latency: got %0d want %0d", name, lat, CHUNKS + 1);
    else n_pass++;
    n_total++;
    if ({res_id, res_count} !== {id, exp_cnt})
      $display("FAIL %s_result: got id=%b cnt=%0d want id=%b cnt=%0d", name, res_id, res_count, id, exp_cnt);
    else n_pass++;
    tick();
  endtask

  task automatic test_single_words();
    run_word(1'b0, 28'hFFFFFFF, 5'd28, "all_ones");
    run_word(1'b1, 28'h0000001, 5'd1,  "first_chunk");
    run_word(1'b1, 28'h8000000, 5'd1,  "last_chunk");
    run_word(1'b0, 28'h0000000, 5'd0,  "all_zeros");
  endtask

  task automatic test_round_robin();
    logic g_exp[3];
    int gi, nres;
    logic [CNT_W:0] item;
    g_exp[0] = 1'b0; g_exp[1] = 1'b1; g_exp[2] = 1'b0;
    do_reset();
    exp_q.delete();
    exp_q.push_back({1'b0, 5'd7});
    exp_q.push_back({1'b1, 5'd0});
    exp_q.push_back({1'b0, 5'd7});
    res_ready = 1'b1;
    req0_data = 28'h000007F; req1_data = 28'h0000000;
    req0_valid = 1'b1; req1_valid = 1'b1;
    gi = 0; nres = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (req0_ready && req1_ready) begin
        n_total++;
        $display("FAIL rr_both_ready: got 11 want one-hot");
      end else if (req0_ready || req1_ready) begin
        n_total++;
        if (gi >= 3)
          $display("FAIL rr_extra_grant: got grant %0d want none", gi);
        else if (req1_ready !== g_exp[gi])
          $display("FAIL rr_grant%0d: got id %b want %b", gi, req1_ready, g_exp[gi]);
        else n_pass++;
        gi++;
      end
      if (res_valid) begin
        n_total++;
        if (exp_q.size() == 0)
          $display("FAIL rr_extra_result: got id=%b cnt=%0d want none", res_id, res_count);
        else begin
          item = exp_q.pop_front();
          if ({res_id, res_count} !== item)
            $display("FAIL rr_result%0d: got id=%b cnt=%0d want id=%b cnt=%0d",
                     nres, res_id, res_count, item[CNT_W], item[CNT_W-1:0]);
          else n_pass++;
        end
        nres++;
      end
      tick();
      if (nres == 3) break;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    n_total++;
    if (nres !== 3 || gi !== 3)
      $display("FAIL rr_counts: got results=%0d grants=%0d want 3 3", nres, gi);
    else n_pass++;
  endtask

  task automatic test_hold();
    int lat;
    res_ready = 1'b0;
    req0_valid = 1'b1; req0_data = 28'hA5A5A5A;
    @(negedge clk);
    tick();
    req0_valid = 1'b0;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (res_valid === 1'b1) begin lat = k; break; end
      tick();
    end
    n_total++;
    if (lat !== CHUNKS + 1)
      $display("FAIL hold_latency: got %0d want %0d", lat, CHUNKS + 1);
    else n_pass++;
    tick();
    req0_valid = 1'b1; req1_valid = 1'b1;   // must not be granted while DONE
    for (int h = 0; h < 3; h++) begin
      @(negedge clk);
      n_total++;
      if ({res_valid, res_count, res_id, busy, req0_ready, req1_ready} !==
          {1'b1, 5'd14, 1'b0, 1'b1, 1'b0, 1'b0})
        $display("FAIL hold_cycle%0d: got rv=%b cnt=%0d id=%b busy=%b rdy=%b%b want rv=1 cnt=14 id=0 busy=1 rdy=00",
                 h, res_valid, res_count, res_id, busy, req1_ready, req0_ready);
      else n_pass++;
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    tick();
    @(negedge clk);
    n_total++;
    if ({dbg_state, res_valid, busy} !== {IDLE, 1'b0, 1'b0})
      $display("FAIL hold_retire: got st=%0d rv=%b busy=%b want st=0 rv=0 busy=0", dbg_state, res_valid, busy);
    else n_pass++;
    tick();
  endtask

  task automatic test_reset_in_run();
    int stray;
    do_reset();
    res_ready = 1'b1;
    req0_valid = 1'b1; req0_data = 28'hFFFFFFF;
    @(negedge clk);
    tick();                      // RUN cycle 1
    req0_valid = 1'b0;
    @(negedge clk);
    n_total++;
    if (busy !== 1'b1)
      $display("FAIL rstrun_busy: got %b want 1", busy);
    else n_pass++;
    tick();                      // RUN cycle 2
    rst = 1'b1;
    @(negedge clk);
    tick();
    rst = 1'b0;
    @(negedge clk);
    n_total++;
    if ({dbg_state, res_valid, busy} !== {IDLE, 1'b0, 1'b0})
      $display("FAIL rstrun_idle: got st=%0d rv=%b busy=%b want st=0 rv=0 busy=0", dbg_state, res_valid, busy);
    else n_pass++;
    stray = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      @(negedge clk);
      if (res_valid) stray++;
    end
    n_total++;
    if (stray !== 0)
      $display("FAIL rstrun_no_result: got %0d result cycles want 0", stray);
    else n_pass++;
    // rr must favour req0 again; drop both valids before the edge.
    tick();
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk);
    n_total++;
    if ({req1_ready, req0_ready} !== 2'b01)
      $display("FAIL rstrun_rr: got %b%b want 01", req1_ready, req0_ready);
    else n_pass++;
    #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    @(negedge clk);
    n_total++;
    if (dbg_state !== IDLE)
      $display("FAIL withdraw_no_capture: got st=%0d want 0", dbg_state);
    else n_pass++;
    tick();
    run_word(1'b1, 28'h0000003, 5'd2, "after_rst");
  endtask

  task automatic test_back_to_back();
    logic [WORD_W-1:0] words[4];
    logic [CNT_W-1:0]  cnts[4];
    logic [CNT_W:0]    item;
    int sent, got, last_res, stray;
    logic hs;
    words[0] = 28'hFFFFFFF; cnts[0] = 5'd28;
    words[1] = 28'h0000000; cnts[1] = 5'd0;
    words[2] = 28'h1234567; cnts[2] = 5'd12;
    words[3] = 28'h8000001; cnts[3] = 5'd2;
    exp_q.delete();
    res_ready = 1'b1;
    sent = 0; got = 0; last_res = -1;
    req0_valid = 1'b1; req0_data = words[0];
    for (int c = 0; c < 80 && got < 4; c++) begin
      @(negedge clk);
      hs = req0_valid && req0_ready;
      if (hs) exp_q.push_back({1'b0, cnts[sent]});
      if (res_valid) begin
        n_total++;
        if (exp_q.size() == 0)
          $display("FAIL b2b_extra_result: got cnt=%0d want none", res_count);
        else begin
          item = exp_q.pop_front();
          if ({res_id, res_count} !== item)
            $display("FAIL b2b_result%0d: got id=%b cnt=%0d want id=%b cnt=%0d",
                     got, res_id, res_count, item[CNT_W], item[CNT_W-1:0]);
          else n_pass++;
        end
        if (last_res >= 0) begin
          n_total++;
          if (c - last_res !== CHUNKS + 2)
            $display("FAIL b2b_spacing%0d: got %0d want %0d", got, c - last_res, CHUNKS + 2);
          else n_pass++;
        end
        last_res = c;
        got++;
      end
      tick();
      if (hs) begin
        sent++;
        if (sent < 4) req0_data = words[sent];
        else req0_valid = 1'b0;
      end
    end
    req0_valid = 1'b0;
    stray = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (res_valid) stray++;
      tick();
    end
    n_total++;
    if (got !== 4 || exp_q.size() !== 0 || stray !== 0)
      $display("FAIL b2b_totals: got results=%0d pending=%0d extra=%0d want 4 0 0", got, exp_q.size(), stray);
    else n_pass++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_words();
    test_round_robin();
    test_hold();
    test_reset_in_run();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
